regfile_scoreboard: RTL



---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_read_port.sv | 40 ++++
 rtl/regfile_scoreboard.sv | 135 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register file with pending-write scoreboard:
// default geometry and MIPS register indices used by the debug taps
// (enabled with the REGFILE_DEBUG_TAPS_EN macro).
package regfile_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_ADDR_BITS = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_AT   = 1;
  localparam int REG_V0   = 2;
  localparam int REG_V1   = 3;
  localparam int REG_A0   = 4;
  localparam int REG_A1   = 5;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: stored value, write-to-read bypass,
// hardwired-zero handling and busy (pending and not being written back now).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int ZERO_REG  = 1,
  localparam int DEPTH    = 2 ** ADDR_BITS
) (
  input  logic [ADDR_BITS-1:0]        addr,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]            pend,
  input  logic                        wr_en,
  input  logic [ADDR_BITS-1:0]        wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            data,
  output logic                        busy
);

  logic bypass;
  logic is_zero;

  // Select stored data, override with in-flight write, force zero last so
  // register 0 reads 0 even when a bypass would apply.
  always_comb begin
    bypass  = wr_en && (wr_addr == addr);
    is_zero = (ZERO_REG != 0) && (addr == '0);
    data    = regs[addr];
    if (bypass) begin
      data = wr_data;
    end
    if (is_zero) begin
      data = '0;
    end
    // A same-cycle writeback releases the stall since the bypass supplies data.
    busy = pend[addr] && !bypass;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised 2-read/1-write register file with synchronous reset,
// write-to-read bypass and a per-register pending-write scoreboard with a
// registered pending count. Optional macro REGFILE_DEBUG_TAPS_EN adds
// outputs exposing stored registers at, v0, v1, a0, a1, sp, ra.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int ZERO_REG  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] Aa,
  input  logic [ADDR_BITS-1:0] Ab,
  output logic [WIDTH-1:0]     Da,
  output logic [WIDTH-1:0]     Db,
  input  logic [ADDR_BITS-1:0] Aw,
  input  logic [WIDTH-1:0]     Dw,
  input  logic                 WrEn,
  input  logic                 IssEn,
  input  logic [ADDR_BITS-1:0] IssAddr,
  output logic                 BusyA,
  output logic                 BusyB,
  output logic [ADDR_BITS:0]   PendCount
`ifdef REGFILE_DEBUG_TAPS_EN
  ,
  output logic [WIDTH-1:0]     dbg_at,
  output logic [WIDTH-1:0]     dbg_v0,
  output logic [WIDTH-1:0]     dbg_v1,
  output logic [WIDTH-1:0]     dbg_a0,
  output logic [WIDTH-1:0]     dbg_a1,
  output logic [WIDTH-1:0]     dbg_sp,
  output logic [WIDTH-1:0]     dbg_ra
`endif
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] CNT_ONE = 1;

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]            pend_q, pend_d;
  logic [ADDR_BITS:0]          pend_count_q, pend_count_d;
  logic                        wr_ok;
  logic                        iss_ok;
  logic                        cnt_inc;
  logic                        cnt_dec;

  // Write decode and scoreboard next state; set beats clear on the same address.
  always_comb begin
    wr_ok  = WrEn && !((ZERO_REG != 0) && (Aw == '0));
    iss_ok = IssEn && !((ZERO_REG != 0) && (IssAddr == '0));
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_ok) begin
      regs_d[Aw] = Dw;
    end
    if (WrEn) begin
      pend_d[Aw] = 1'b0;
    end
    if (iss_ok) begin
      pend_d[IssAddr] = 1'b1;
    end
    // Count only real bit transitions so the count tracks popcount(pend).
    cnt_inc = iss_ok && !pend_q[IssAddr];
    cnt_dec = WrEn && pend_q[Aw] && !(iss_ok && (IssAddr == Aw));
    pend_count_d = pend_count_q;
    if (cnt_inc && !cnt_dec) begin
      pend_count_d = pend_count_q + CNT_ONE;
    end else if (cnt_dec && !cnt_inc) begin
      pend_count_d = pend_count_q - CNT_ONE;
    end
  end

  // State registers; reset discards contents and all pending state.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q       <= '0;
      pend_q       <= '0;
      pend_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      pend_q       <= pend_d;
      pend_count_q <= pend_count_d;
    end
  end

  assign PendCount = pend_count_q;

  regfile_read_port #(
    .WIDTH    (WIDTH),
    .ADDR_BITS(ADDR_BITS),
    .ZERO_REG (ZERO_REG)
  ) u_port_a (
    .addr   (Aa),
    .regs   (regs_q),
    .pend   (pend_q),
    .wr_en  (WrEn),
    .wr_addr(Aw),
    .wr_data(Dw),
    .data   (Da),
    .busy   (BusyA)
  );

  regfile_read_port #(
    .WIDTH    (WIDTH),
    .ADDR_BITS(ADDR_BITS),
    .ZERO_REG (ZERO_REG)
  ) u_port_b (
    .addr   (Ab),
    .regs   (regs_q),
    .pend   (pend_q),
    .wr_en  (WrEn),
    .wr_addr(Aw),
    .wr_data(Dw),
    .data   (Db),
    .busy   (BusyB)
  );

`ifdef REGFILE_DEBUG_TAPS_EN
  // Taps show stored values only; they never see the bypass.
  if (ADDR_BITS >= 5) begin : g_dbg_taps
    assign dbg_at = regs_q[REG_AT];
    assign dbg_v0 = regs_q[REG_V0];
    assign dbg_v1 = regs_q[REG_V1];
    assign dbg_a0 = regs_q[REG_A0];
    assign dbg_a1 = regs_q[REG_A1];
    assign dbg_sp = regs_q[REG_SP];
    assign dbg_ra = regs_q[REG_RA];
  end else begin : g_dbg_taps_bad
    $error("regfile_scoreboard: debug taps need ADDR_BITS >= 5");
  end
`endif

endmodule
